// File: rtl/zx_iobus_master_if.sv
// zx_iobus_master_if: request/response handshake and ZX-side Z80 I/O bus
// signals for zx_iobus_master.
//   master modport : the bus-cycle initiator (drives strobes, address, data
//                    drive, status; receives request, d_in, n_wait, n_iorqge)
//   slave  modport : requester plus bus responder (the opposite view)
interface zx_iobus_master_if;
  // request side
  logic        req;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        busy;
  logic        done;
  logic [7:0]  rdata;
  logic        claimed;
  logic        timeout;
  // ZX bus side
  logic [15:0] a;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  d_in;
  logic        n_iorq;
  logic        n_rd;
  logic        n_wr;
  logic        n_m1;
  logic        n_mreq;
  logic        n_wait;
  logic        n_iorqge;

  modport master (
    input  req, req_wr, req_addr, req_wdata, d_in, n_wait, n_iorqge,
    output busy, done, rdata, claimed, timeout,
           a, d_out, d_oe, n_iorq, n_rd, n_wr, n_m1, n_mreq
  );

  modport slave (
    output req, req_wr, req_addr, req_wdata, d_in, n_wait, n_iorqge,
    input  busy, done, rdata, claimed, timeout,
           a, d_out, d_oe, n_iorq, n_rd, n_wr, n_m1, n_mreq
  );
endinterface

// File: rtl/zx_iobus_master.sv
// zx_iobus_master: Z80 IORQ read/write cycle generator for board self-test
// and standalone operation. A single request (port address, direction,
// write data) becomes a T1/T2/TW.../T3 I/O cycle with T-states of T_DIV
// clk32 cycles, IOREQ_TW automatic waits, n_wait-driven extra waits bounded
// by WAIT_MAX, and a one-cycle done pulse carrying rdata/claimed/timeout.
// Ports:
//   clk32 : system clock, rising edge
//   rst   : asynchronous active-high reset
//   bus   : zx_iobus_master_if.master (request handshake + ZX I/O bus)
module zx_iobus_master #(
  parameter int unsigned T_DIV    = 9,    // clk32 cycles per T-state, 4..63
  parameter int unsigned IOREQ_TW = 1,    // automatic wait T-states, 1..3
  parameter int unsigned WAIT_MAX = 255   // extra n_wait T-states, 1..255
) (
  input logic               clk32,
  input logic               rst,
  zx_iobus_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3
  } state_t;

  localparam int unsigned HALF     = T_DIV / 2;
  localparam logic [5:0]  CNT_LAST = 6'(T_DIV - 1);
  // done/d_oe are registered one cycle early so they appear in the T3 tick cycle
  localparam logic [5:0]  CNT_DONE = 6'(T_DIV - 2);
  // strobes are registered high one cycle early so they read high at cnt==HALF
  localparam logic [5:0]  CNT_REL  = 6'(HALF - 1);
  localparam logic [1:0]  TW_LAST  = 2'(IOREQ_TW - 1);
  localparam logic [7:0]  WAIT_LIM = 8'(WAIT_MAX);

  state_t     state;
  logic [5:0] cnt;
  logic [1:0] tw_cnt;
  logic [7:0] ext_cnt;
  logic       in_extra;
  logic       lat_wr;
  logic       wait_s1;
  logic       wait_sync;
  logic       iorqge_s1;
  logic       iorqge_sync;
  logic       tick;

  assign tick       = (cnt == CNT_LAST);
  assign bus.n_m1   = 1'b1;
  assign bus.n_mreq = 1'b1;

  // responder inputs are asynchronous to clk32
  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      wait_s1     <= 1'b1;
      wait_sync   <= 1'b1;
      iorqge_s1   <= 1'b1;
      iorqge_sync <= 1'b1;
    end else begin
      wait_s1     <= bus.n_wait;
      wait_sync   <= wait_s1;
      iorqge_s1   <= bus.n_iorqge;
      iorqge_sync <= iorqge_s1;
    end
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tw_cnt      <= '0;
      ext_cnt     <= '0;
      in_extra    <= 1'b0;
      lat_wr      <= 1'b0;
      bus.a       <= '0;
      bus.d_out   <= '0;
      bus.d_oe    <= 1'b0;
      bus.n_iorq  <= 1'b1;
      bus.n_rd    <= 1'b1;
      bus.n_wr    <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.rdata   <= '1;
      bus.claimed <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      bus.done <= 1'b0;

      if (state != S_IDLE) begin
        cnt <= tick ? '0 : cnt + 6'd1;
      end

      case (state)
        S_IDLE: begin
          if (bus.req) begin
            state       <= S_T1;
            cnt         <= '0;
            tw_cnt      <= '0;
            ext_cnt     <= '0;
            in_extra    <= 1'b0;
            lat_wr      <= bus.req_wr;
            bus.a       <= bus.req_addr;
            bus.busy    <= 1'b1;
            bus.claimed <= 1'b0;
            bus.timeout <= 1'b0;
            if (bus.req_wr) begin
              bus.d_out <= bus.req_wdata;
              bus.d_oe  <= 1'b1;
            end
          end
        end

        S_T1: begin
          if (tick) begin
            state      <= S_T2;
            bus.n_iorq <= 1'b0;
            bus.n_rd   <= lat_wr;
            bus.n_wr   <= ~lat_wr;
          end
        end

        S_T2: begin
          if (tick) begin
            state       <= S_TW;
            bus.claimed <= ~iorqge_sync;
            tw_cnt      <= '0;
            in_extra    <= 1'b0;
          end
        end

        S_TW: begin
          if (tick) begin
            if (!in_extra && (tw_cnt != TW_LAST)) begin
              tw_cnt <= tw_cnt + 2'd1;
            end else if (!wait_sync && (ext_cnt != WAIT_LIM)) begin
              ext_cnt  <= ext_cnt + 8'd1;
              in_extra <= 1'b1;
            end else begin
              // reaching here with n_wait still low means the limit was hit
              if (!wait_sync) begin
                bus.timeout <= 1'b1;
              end
              state <= S_T3;
            end
          end
        end

        S_T3: begin
          if (cnt == CNT_REL) begin
            bus.n_iorq <= 1'b1;
            bus.n_rd   <= 1'b1;
            bus.n_wr   <= 1'b1;
            if (!lat_wr) begin
              bus.rdata <= bus.timeout ? 8'hFF : bus.d_in;
            end
          end
          if (cnt == CNT_DONE) begin
            bus.done <= 1'b1;
            bus.d_oe <= 1'b0;
          end
          if (tick) begin
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/zx_iobus_master.md
# zx_iobus_master

Z80 I/O bus-cycle initiator for the multisound board: given a single-word request (port address, read/write, data), it generates a cycle-accurate Z80 IORQ read or write on the ZX-side bus (`a`, `d`, `n_iorq`, `n_rd`, `n_wr`) at a 3.5 MHz-class T-state rate derived from `clk32`. It is the host end of the port protocol our peripheral logic decodes (0xFFFD/0xBFFD, 0xFF, 0xB3/0xBB, Soundrive 0x?F). It honours `n_wait`, samples the responder's `n_iorqge` claim and reports completion with a one-cycle `done`. It serves board self-test and standalone operation, where no real Z80 is present.

## Interface
- `T_DIV`, 9: `clk32` cycles per T-state; legal range 4..63.
- `IOREQ_TW`, 1: automatic wait T-states inserted after T2; legal range 1..3.
- `WAIT_MAX`, 255: maximum extra wait T-states granted to `n_wait` before timeout; legal range 1..255.
- `clk32  in  1`: system clock; all logic on posedge.
- `rst  in  1`: asynchronous, active-high reset.
- `req  in  1`: request strobe; sampled only in IDLE.
- `req_wr  in  1`: 1 = write cycle, 0 = read cycle.
- `req_addr  in  16`: port address.
- `req_wdata  in  8`: write data.
- `busy  out  1`: high from the cycle after acceptance through the `done` cycle.
- `done  out  1`: one-cycle completion pulse.
- `rdata  out  8`: read result, valid from `done` until the next `done`.
- `claimed  out  1`: responder asserted `n_iorqge` low in T2; valid with `done`.
- `timeout  out  1`: the wait limit was hit; valid with `done`.
- `a  out  16`: address bus.
- `d_out  out  8`: data bus drive value.
- `d_oe  out  1`: data bus output enable (tristate buffer sits in top level).
- `d_in  in  8`: data bus input.
- `n_iorq`, `n_rd`, `n_wr`, `n_m1`, `n_mreq`  `out  1`: Z80 strobes, active low; `n_m1`/`n_mreq` are constant 1.
- `n_wait  in  1`: responder wait request, active low.
- `n_iorqge  in  1`: responder port claim, active low.

## Operation
- Reset values: `a`=0, `d_out`=0, `d_oe`=0, all strobes 1, `busy`=0, `done`=0, `rdata`=0xFF, `claimed`=0, `timeout`=0, state IDLE, counters 0.
- `n_wait` and `n_iorqge` each pass through a 2-FF synchronizer before use.
- T-state counter `cnt` runs 0..T_DIV-1. "Tick" means `cnt`==T_DIV-1. `HALF` = floor(T_DIV/2).
- IDLE: if `req`=1, latch addr/wr/wdata and go to T1 with `cnt`=0. `req` is ignored in every other state.
- T1: `a` = latched address for the whole cycle, held until the next request. For writes, `d_out` = wdata and `d_oe`=1 from the first T1 cycle. On tick, go to T2.
- T2: `n_iorq` low together with `n_rd` (read) or `n_wr` (write), registered from the first T2 cycle. On tick, `claimed` <= ~n_iorqge_sync, then go to TW.
- TW: runs IOREQ_TW mandatory T-states. On the tick of the last mandatory TW, and of every extra TW:
  - if n_wait_sync=0 and the extra count < WAIT_MAX, add one extra TW and increment the count;
  - if n_wait_sync=0 and the count = WAIT_MAX, set `timeout`=1 and go to T3;
  - otherwise go to T3.
- T3: at `cnt`==HALF-1, `rdata` <= d_in for reads (0xFF if `timeout`); for writes, `rdata` is unchanged.
  - At `cnt`==HALF, strobes return to 1.
  - On tick: `d_oe`=0, `done`=1, `busy`=0, state IDLE.
- `claimed`/`timeout` are cleared at acceptance of the next request.
- `rst` asserted mid-cycle: all outputs take reset values immediately (asynchronously) and any pending request is dropped.

## Timing
- `req` accepted at edge k → T1 covers k+1..k+T_DIV. T2 starts at k+T_DIV+1. Each T-state is exactly T_DIV cycles.
- No extra waits: `done` in cycle k+(3+IOREQ_TW)·T_DIV. Each extra TW adds T_DIV.
- Strobe low width = (1+IOREQ_TW+extra)·T_DIV + HALF cycles.
- Earliest next acceptance: the cycle after `done`. Back-to-back period = (3+IOREQ_TW)·T_DIV+1.
- `n_wait` must be low at the bus ≥2 cycles before a TW tick for that tick to see it.

## Test plan
- Write 0xBFFD←0x5A, defaults, `n_wait`=1: `a`=0xBFFD from k+1; `d_oe`=1 k+1..k+35; `n_iorq`/`n_wr` low k+10..k+31, `n_rd` stays 1; `done` at k+36; `busy` k+1..k+36.
- Read 0xFFFD, `d_in`=0xA5, `n_iorqge` low throughout: `n_rd` low k+10..k+31; `d_oe` never 1; `rdata`=0xA5 and `claimed`=1 at `done` (k+36).
- Read with `n_wait` held low so exactly 2 TW ticks see it: `done` at k+54, `timeout`=0, strobes low 40 cycles.
- `WAIT_MAX`=4, `n_wait` stuck low, read: `done` at k+72, `timeout`=1, `rdata`=0xFF.
- `req` pulsed during T2 is ignored (exactly one `done`). `rst` asserted mid-T2: strobes 1 and `busy`=0 in the same cycle. After `rst` drops, a new write completes normally 36 cycles after acceptance.
- Two back-to-back requests (`req` held high): second acceptance on the cycle after the first `done`, second `done` 37 cycles after the first.
